// File: rtl/keypad_if.sv
// Keypad pin bundle plus the decoded key outputs that feed the downstream lock FSM.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] keypad_value;
  logic       keypress;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output keypad_value,
    output keypress,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  keypad_value,
    input  keypress,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, debounce and hex decode.
// Emits one keypress strobe per accepted press and tracks the held key until release.
module keypad_scanner #(
  parameter int clk_freq     = 50_000_000,
  parameter int scan_time_us = 1000,
  parameter int stable_time  = 10
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  localparam int SCAN_RAW = clk_freq / 1_000_000 * scan_time_us;
  localparam int SCAN_CYC = (SCAN_RAW < 4) ? 4 : SCAN_RAW;
  localparam int DB_RAW   = clk_freq / 1000 * stable_time;
  localparam int DB_CYC   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int SCAN_W   = $clog2(SCAN_CYC);
  localparam int DB_W     = $clog2(DB_CYC + 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [3:0]        row_p0;
  logic [3:0]        row_p1;
  state_t            state;
  state_t            state_nx;
  logic [1:0]        col_idx;
  logic [1:0]        col_idx_nx;
  logic [1:0]        row_idx;
  logic [1:0]        row_idx_nx;
  logic [SCAN_W-1:0] dwell;
  logic [SCAN_W-1:0] dwell_nx;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nx;
  logic [3:0]        col_q;
  logic [3:0]        value_q;
  logic [3:0]        value_nx;
  logic              keypress_q;
  logic              keypress_nx;
  logic              held_q;
  logic              held_nx;
  logic              low_ok;
  logic [1:0]        low_idx;

  // Exactly one row low -> {valid, row index}; idle or ghosted patterns are invalid.
  function automatic logic [2:0] single_low(input logic [3:0] v);
    case (v)
      4'b1110: single_low = {1'b1, 2'd0};
      4'b1101: single_low = {1'b1, 2'd1};
      4'b1011: single_low = {1'b1, 2'd2};
      4'b0111: single_low = {1'b1, 2'd3};
      default: single_low = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    case ({r, c})
      4'h0: key_map = 4'h1;
      4'h1: key_map = 4'h2;
      4'h2: key_map = 4'h3;
      4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;
      4'h5: key_map = 4'h5;
      4'h6: key_map = 4'h6;
      4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;
      4'h9: key_map = 4'h8;
      4'hA: key_map = 4'h9;
      4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;
      4'hD: key_map = 4'hF;
      4'hE: key_map = 4'hE;
      default: key_map = 4'hD;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous row pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= kp.row;
      row_p1 <= row_p0;
    end
  end

  assign {low_ok, low_idx} = single_low(row_p1);

  always_comb begin
    state_nx    = state;
    col_idx_nx  = col_idx;
    row_idx_nx  = row_idx;
    dwell_nx    = dwell;
    db_cnt_nx   = db_cnt;
    value_nx    = value_q;
    keypress_nx = 1'b0;
    held_nx     = held_q;
    case (state)
      SCAN: begin
        // Rows are only trusted on the last dwell cycle so the column drive has settled.
        if (dwell == SCAN_W'(SCAN_CYC - 1)) begin
          dwell_nx = '0;
          if (low_ok) begin
            row_idx_nx = low_idx;
            db_cnt_nx  = '0;
            state_nx   = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_p1 == ~(4'b0001 << row_idx)) begin
          if (db_cnt == DB_W'(DB_CYC - 1)) begin
            db_cnt_nx   = '0;
            state_nx    = HELD;
            value_nx    = key_map(col_idx, row_idx);
            keypress_nx = 1'b1;
            held_nx     = 1'b1;
          end else begin
            db_cnt_nx = db_cnt + 1'b1;
          end
        end else begin
          db_cnt_nx  = '0;
          dwell_nx   = '0;
          col_idx_nx = col_idx + 2'd1;
          state_nx   = SCAN;
        end
      end
      HELD: begin
        if (row_p1 == 4'hF) begin
          if (db_cnt == DB_W'(DB_CYC - 1)) begin
            db_cnt_nx  = '0;
            dwell_nx   = '0;
            held_nx    = 1'b0;
            col_idx_nx = col_idx + 2'd1;
            state_nx   = SCAN;
          end else begin
            db_cnt_nx = db_cnt + 1'b1;
          end
        end else begin
          db_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = SCAN;
        dwell_nx = '0;
        db_cnt_nx = '0;
      end
    endcase
  end

  // Column drive is registered from the next index so it is always exactly one-low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      row_idx    <= 2'd0;
      dwell      <= '0;
      db_cnt     <= '0;
      col_q      <= 4'b1110;
      value_q    <= 4'h0;
      keypress_q <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      col_idx    <= col_idx_nx;
      row_idx    <= row_idx_nx;
      dwell      <= dwell_nx;
      db_cnt     <= db_cnt_nx;
      col_q      <= ~(4'b0001 << col_idx_nx);
      value_q    <= value_nx;
      keypress_q <= keypress_nx;
      held_q     <= held_nx;
    end
  end

  assign kp.col          = col_q;
  assign kp.keypad_value = value_q;
  assign kp.keypress     = keypress_q;
  assign kp.key_held     = held_q;

endmodule
